// File: rtl/multicycle_cpu.sv
// rtl/multicycle_cpu.sv - multi-cycle CPU core over a shared req/ack memory bus
//
// Fetch, decode, execute, memory and writeback are sequenced by one FSM; a
// single memory bus carries both instruction fetches and LD/ST transfers, so
// any number of wait cycles is tolerated. The register file is internal and
// R0 always reads as zero.
//
// Optional feature macro: MULTICYCLE_CPU_MUL_EN (op 0xB = MUL when defined,
// illegal otherwise).
//
// Parameters:
//   DATA_W     datapath/register width (>= 16; instruction is mem_rdata[15:0])
//   ADDR_W     memory address / PC width
//   REG_COUNT  implemented registers (2..16)
//   RESET_PC   PC value after reset
//
// Ports:
//   clk         in   rising-edge clock
//   reset       in   asynchronous active-low reset
//   run         in   1 = start next fetch, 0 = pause before the next fetch
//   mem_req     out  bus request, held until mem_ack
//   mem_we      out  1 = write (ST), 0 = read (fetch/LD)
//   mem_addr    out  bus address
//   mem_wdata   out  write data
//   mem_rdata   in   read data, valid in the mem_ack cycle
//   mem_ack     in   transfer completes in a cycle with mem_req & mem_ack
//   pc          out  current PC
//   output_reg  out  last value written by ST
//   halted      out  HALT executed
//   illegal_op  out  sticky, undefined opcode seen
module multicycle_cpu #(
    parameter int                DATA_W    = 16,
    parameter int                ADDR_W    = 16,
    parameter int                REG_COUNT = 16,
    parameter logic [ADDR_W-1:0] RESET_PC  = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              run,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic [ADDR_W-1:0] pc,
    output logic [DATA_W-1:0] output_reg,
    output logic              halted,
    output logic              illegal_op
);

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_WB,
        S_HALT
    } state_t;

    localparam int XW = (DATA_W > ADDR_W) ? DATA_W : ADDR_W;

    state_t            state;
    logic [15:0]       instr;
    logic [DATA_W-1:0] a_q;
    logic [DATA_W-1:0] b_q;
    logic [DATA_W-1:0] res_q;
    logic [ADDR_W-1:0] npc_q;
    logic [DATA_W-1:0] regs [REG_COUNT];

    logic [3:0]        op;
    logic [3:0]        rd;
    logic [3:0]        rs1;
    logic [3:0]        rs2;
    logic [DATA_W-1:0] rs1_val;
    logic [DATA_W-1:0] rs2_val;
    logic [DATA_W-1:0] alu_res;
    logic              wr_rd;
    logic              illegal;
    logic [XW-1:0]     a_ext;
    logic [ADDR_W-1:0] a_addr;
    logic [ADDR_W-1:0] pc_inc;
    logic [ADDR_W-1:0] br_target;

    assign op  = instr[15:12];
    assign rd  = instr[11:8];
    assign rs1 = instr[7:4];
    assign rs2 = instr[3:0];

    // Unimplemented register numbers read as zero.
    always_comb begin
        rs1_val = '0;
        rs2_val = '0;
        if (32'(rs1) < REG_COUNT) rs1_val = regs[rs1];
        if (32'(rs2) < REG_COUNT) rs2_val = regs[rs2];
    end

    // Address from rs1, zero-extended when the datapath is narrower than the bus.
    assign a_ext     = XW'(a_q);
    assign a_addr    = a_ext[ADDR_W-1:0];
    assign pc_inc    = pc + ADDR_W'(1);
    assign br_target = pc + {{(ADDR_W-4){instr[3]}}, instr[3:0]};

    always_comb begin
        alu_res = '0;
        wr_rd   = 1'b0;
        illegal = 1'b0;
        case (op)
            4'h1: begin alu_res = a_q + b_q; wr_rd = 1'b1; end
            4'h2: begin alu_res = a_q - b_q; wr_rd = 1'b1; end
            4'h3: begin alu_res = a_q & b_q; wr_rd = 1'b1; end
            4'h4: begin alu_res = a_q | b_q; wr_rd = 1'b1; end
            4'h5: begin alu_res = a_q ^ b_q; wr_rd = 1'b1; end
            4'h6: begin alu_res = DATA_W'(instr[7:0]); wr_rd = 1'b1; end
            4'h7: wr_rd = 1'b1;
`ifdef MULTICYCLE_CPU_MUL_EN
            4'hB: begin alu_res = a_q * b_q; wr_rd = 1'b1; end
`endif
            4'h0, 4'h8, 4'h9, 4'hF: ;
            default: illegal = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= S_FETCH;
            instr      <= '0;
            a_q        <= '0;
            b_q        <= '0;
            res_q      <= '0;
            npc_q      <= '0;
            pc         <= RESET_PC;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            output_reg <= '0;
            halted     <= 1'b0;
            illegal_op <= 1'b0;
            for (int i = 0; i < REG_COUNT; i++) regs[i] <= '0;
        end else begin
            case (state)
                S_FETCH: begin
                    // A request already raised in WB gives 0-wait back-to-back fetches.
                    if (mem_req) begin
                        if (mem_ack) begin
                            instr   <= mem_rdata[15:0];
                            mem_req <= 1'b0;
                            state   <= S_DECODE;
                        end
                    end else if (run) begin
                        mem_req  <= 1'b1;
                        mem_we   <= 1'b0;
                        mem_addr <= pc;
                    end
                end
                S_DECODE: begin
                    a_q <= rs1_val;
                    b_q <= rs2_val;
                    if (illegal) illegal_op <= 1'b1;
                    state <= S_EXEC;
                end
                S_EXEC: begin
                    res_q <= alu_res;
                    npc_q <= (op == 4'h9 && a_q != '0) ? br_target : pc_inc;
                    if (op == 4'h7 || op == 4'h8) begin
                        mem_req  <= 1'b1;
                        mem_we   <= (op == 4'h8);
                        mem_addr <= a_addr;
                        if (op == 4'h8) mem_wdata <= b_q;
                        state <= S_MEM;
                    end else begin
                        state <= S_WB;
                    end
                end
                S_MEM: begin
                    if (mem_ack) begin
                        mem_req <= 1'b0;
                        mem_we  <= 1'b0;
                        if (op == 4'h7) res_q <= mem_rdata;
                        if (op == 4'h8) output_reg <= mem_wdata;
                        state <= S_WB;
                    end
                end
                S_WB: begin
                    if (wr_rd && rd != 4'd0 && 32'(rd) < REG_COUNT) regs[rd] <= res_q;
                    if (op == 4'hF) begin
                        halted <= 1'b1;
                        state  <= S_HALT;
                    end else begin
                        pc       <= npc_q;
                        mem_req  <= run;
                        mem_we   <= 1'b0;
                        mem_addr <= npc_q;
                        state    <= S_FETCH;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_cpu.sv
// tb/tb_multicycle_cpu.sv - self-checking bench for multicycle_cpu
module tb_multicycle_cpu;

    logic        clk;
    logic        reset;
    logic        run;
    logic        mem_req;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;
    logic        mem_ack;
    logic [15:0] pc;
    logic [15:0] output_reg;
    logic        halted;
    logic        illegal_op;

    multicycle_cpu dut (
        .clk(clk), .reset(reset), .run(run),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .pc(pc), .output_reg(output_reg), .halted(halted), .illegal_op(illegal_op)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int fails  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Bus-side memory and a separate ISA-level model with its own memory copy.
    logic [15:0] mem   [65536];
    logic [15:0] m_mem [65536];
    logic [15:0] m_regs [16];
    logic [15:0] m_pc, m_out;
    logic        m_halt, m_ill;
    int          m_nextlat;
    int          wait_addr = -1;
    int          wait_n    = 0;

    typedef struct {
        logic [15:0] addr;
        logic        we;
        logic [15:0] wdata;
        logic        fetch;
        logic [15:0] out;
        int          lat;
    } tx_t;
    tx_t exp_q[$];

    task automatic load(input int a, input logic [15:0] d);
        mem[a]   = d;
        m_mem[a] = d;
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 65536; i++) begin
            mem[i]   = 16'h0;
            m_mem[i] = 16'h0;
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 16; i++) m_regs[i] = 16'h0;
        m_pc = 16'h0; m_out = 16'h0; m_halt = 1'b0; m_ill = 1'b0;
        m_nextlat = 0;
        exp_q.delete();
    endtask

    function automatic int waits_at(input logic [15:0] a);
        return (int'(a) == wait_addr) ? wait_n : 0;
    endfunction

    // Executes one whole instruction and queues the bus transfers it must cause.
    task automatic model_step();
        logic [15:0] ins, a, b, r, npc;
        logic [3:0]  op, rd;
        logic        wr;
        int          lat;
        tx_t         t;
        ins = m_mem[m_pc];
        op = ins[15:12]; rd = ins[11:8];
        a = m_regs[ins[7:4]]; b = m_regs[ins[3:0]];
        r = 16'h0; wr = 1'b0; lat = 4; npc = m_pc + 16'd1;
        t = '{addr: m_pc, we: 1'b0, wdata: 16'h0, fetch: 1'b1, out: m_out, lat: m_nextlat};
        exp_q.push_back(t);
        case (op)
            4'h0: ;
            4'h1: begin r = a + b; wr = 1'b1; end
            4'h2: begin r = a - b; wr = 1'b1; end
            4'h3: begin r = a & b; wr = 1'b1; end
            4'h4: begin r = a | b; wr = 1'b1; end
            4'h5: begin r = a ^ b; wr = 1'b1; end
            4'h6: begin r = {8'h0, ins[7:0]}; wr = 1'b1; end
            4'h7: begin
                r = m_mem[a]; wr = 1'b1; lat = 5 + waits_at(a);
                t = '{addr: a, we: 1'b0, wdata: 16'h0, fetch: 1'b0, out: 16'h0, lat: 0};
                exp_q.push_back(t);
            end
            4'h8: begin
                m_mem[a] = b; m_out = b; lat = 5 + waits_at(a);
                t = '{addr: a, we: 1'b1, wdata: b, fetch: 1'b0, out: 16'h0, lat: 0};
                exp_q.push_back(t);
            end
            4'h9: if (a != 16'h0) npc = m_pc + {{12{ins[3]}}, ins[3:0]};
`ifdef MULTICYCLE_CPU_MUL_EN
            4'hB: begin r = a * b; wr = 1'b1; end
`endif
            4'hF: m_halt = 1'b1;
            default: m_ill = 1'b1;
        endcase
        if (wr && rd != 4'd0) m_regs[rd] = r;
        if (!m_halt) m_pc = npc;
        m_nextlat = lat + waits_at(npc);
    endtask

    // Memory responder: acks after wait_n cycles when the address is wait_addr.
    initial begin
        int cnt;
        cnt = 0;
        mem_ack = 1'b0;
        mem_rdata = 16'h0;
        forever begin
            @(posedge clk);
            #1;
            if (mem_req && !mem_ack) begin
                if (cnt >= waits_at(mem_addr)) begin
                    mem_ack = 1'b1;
                    mem_rdata = mem[mem_addr];
                    if (mem_we) mem[mem_addr] = mem_wdata;
                    cnt = 0;
                end else begin
                    mem_ack = 1'b0;
                    cnt++;
                end
            end else begin
                mem_ack = 1'b0;
                cnt = 0;
            end
        end
    end

    // Compare process: every bus transfer, bus stability and instruction latency.
    int          cyc = 0;
    int          last_fetch_cyc = 0;
    logic        prev_req = 1'b0, prev_ack = 1'b0, prev_we = 1'b0;
    logic [15:0] prev_addr = 16'h0, prev_wdata = 16'h0;
    logic [15:0] last_wr_addr, last_wr_data, prev_fetch;
    int          fetch2_cnt, req40_cnt, wrap_seen;
    int          fetch_cyc [16];

    always @(negedge clk) begin
        tx_t t;
        cyc++;
        if (!reset) begin
            prev_req = 1'b0;
            prev_ack = 1'b0;
        end else begin
            if (prev_req && prev_ack) chk("req_drop_after_ack", mem_req, 0);
            else if (prev_req && mem_req) begin
                chk("bus_addr_we_stable", {mem_we, mem_addr}, {prev_we, prev_addr});
                if (mem_we) chk("bus_wdata_stable", mem_wdata, prev_wdata);
            end
            if (mem_req && mem_addr == 16'h0040) req40_cnt++;
            if (mem_req && mem_ack) begin
                if (exp_q.size() == 0 && !m_halt) model_step();
                if (exp_q.size() == 0) chk("unexpected_request", {mem_we, mem_addr}, 32'hdead);
                else begin
                    t = exp_q.pop_front();
                    chk("bus_addr", mem_addr, t.addr);
                    chk("bus_we", mem_we, t.we);
                    if (t.we) begin
                        chk("bus_wdata", mem_wdata, t.wdata);
                        last_wr_addr = mem_addr;
                        last_wr_data = mem_wdata;
                    end
                    if (t.fetch) begin
                        chk("pc_at_fetch", pc, t.addr);
                        chk("output_reg_at_fetch", output_reg, t.out);
                        if (t.lat != 0) chk("instr_latency", cyc - last_fetch_cyc, t.lat);
                        last_fetch_cyc = cyc;
                        if (mem_addr == 16'h0002) fetch2_cnt++;
                        if (mem_addr < 16'd16) fetch_cyc[mem_addr[3:0]] = cyc;
                        if (mem_addr == 16'h0000 && prev_fetch == 16'hFFFF) wrap_seen++;
                        prev_fetch = mem_addr;
                    end
                end
            end
            prev_req = mem_req; prev_ack = mem_ack; prev_we = mem_we;
            prev_addr = mem_addr; prev_wdata = mem_wdata;
        end
    end

    task automatic run_program(input bit start_paused);
        int n, bad;
        logic [15:0] pc_hold;
        reset = 1'b0;
        model_reset();
        fetch2_cnt = 0; req40_cnt = 0; wrap_seen = 0;
        last_wr_addr = 16'h0; last_wr_data = 16'h0; prev_fetch = 16'h1234;
        for (int i = 0; i < 16; i++) fetch_cyc[i] = 0;
        run = start_paused ? 1'b0 : 1'b1;
        repeat (2) @(negedge clk);
        #2 reset = 1'b1;
        if (start_paused) begin
            bad = 0;
            repeat (8) begin
                @(negedge clk);
                if (mem_req !== 1'b0) bad++;
            end
            chk("paused_no_request", bad, 0);
            run = 1'b1;
        end
        n = 0;
        while (!halted && n < 400) begin
            @(negedge clk);
            n++;
        end
        chk("halt_within_budget", halted, 1);
        chk("model_halted", m_halt, 1);
        chk("final_pc", pc, m_pc);
        chk("final_output_reg", output_reg, m_out);
        chk("final_illegal_op", illegal_op, m_ill);
        chk("all_transfers_seen", exp_q.size(), 0);
        bad = 0;
        pc_hold = pc;
        repeat (10) begin
            @(negedge clk);
            if (mem_req !== 1'b0 || pc !== pc_hold || halted !== 1'b1) bad++;
        end
        chk("halt_is_terminal", bad, 0);
    endtask

    initial begin
        int n;
        reset = 1'b0;
        run = 1'b1;
        clear_mem();
        model_reset();

        // Reset asserted while a fetch request is pending.
        wait_addr = 0; wait_n = 6;
        repeat (2) @(negedge clk);
        chk("reset_mem_req", mem_req, 0);
        chk("reset_pc", pc, 0);
        #2 reset = 1'b1;
        n = 0;
        while (!mem_req && n < 20) begin @(negedge clk); n++; end
        chk("fetch_requested", mem_req, 1);
        @(posedge clk); #3;
        reset = 1'b0;
        #1;
        chk("async_reset_drops_req", mem_req, 0);
        chk("async_reset_outputs", {mem_we, mem_addr, mem_wdata, output_reg, halted, illegal_op}, 0);
        @(negedge clk); #2 reset = 1'b1;
        @(negedge clk);
        chk("after_release_pc", pc, 0);
        chk("after_release_outputs", {output_reg, halted, illegal_op}, 0);
        wait_addr = -1; wait_n = 0;

        // LDI/LDI/ADD/ST with 0-wait ack.
        clear_mem();
        load(0, 16'h6105); load(1, 16'h62FF); load(2, 16'h1312); load(3, 16'h8013); load(4, 16'hF000);
        run_program(1'b0);
        chk("t2_write_addr", last_wr_addr, 16'h0005);
        chk("t2_write_data", last_wr_data, 16'h0104);
        chk("t2_output_reg", output_reg, 16'h0104);
        chk("t2_model_out", m_out, 16'h0104);
        chk("t2_memory", mem[5], 16'h0104);

        // Countdown loop with BNZ -1, started from a paused core.
        clear_mem();
        load(0, 16'h6103); load(1, 16'h6401); load(2, 16'h2114); load(3, 16'h901F);
        load(4, 16'h8041); load(5, 16'hF000);
        run_program(1'b1);
        chk("t3_sub_iterations", fetch2_cnt, 3);
        chk("t3_fallthrough_pc", pc, 16'h0005);
        chk("t3_output_reg", output_reg, 16'h0000);

        // LD acknowledged after 3 wait cycles.
        clear_mem();
        load(0, 16'h6540); load(1, 16'h7650); load(2, 16'h8006); load(3, 16'hF000);
        load(16'h0040, 16'hBEEF);
        wait_addr = 16'h0040; wait_n = 3;
        run_program(1'b0);
        chk("t4_addr_held_cycles", req40_cnt, 4);
        chk("t4_ld_latency", fetch_cyc[2] - fetch_cyc[1], 8);
        chk("t4_output_reg", output_reg, 16'hBEEF);
        wait_addr = -1; wait_n = 0;

        // Undefined opcode then HALT.
        clear_mem();
        load(0, 16'hC000); load(1, 16'hF000);
        run_program(1'b0);
        chk("t5_illegal_op", illegal_op, 1);
        chk("t5_halt_pc", pc, 16'h0001);

        // PC wraps from 0xFFFF to 0x0000.
        clear_mem();
        load(0, 16'h9023); load(1, 16'h6201); load(2, 16'h902D); load(3, 16'hF000);
        load(16'hFFFF, 16'h0000);
        run_program(1'b0);
        chk("t6_wrap_fetch", wrap_seen, 1);
        chk("t6_halt_pc", pc, 16'h0003);

`ifdef MULTICYCLE_CPU_MUL_EN
        clear_mem();
        load(0, 16'h6110); load(1, 16'hB111); load(2, 16'hB211);
        load(3, 16'h8001); load(4, 16'h8002); load(5, 16'hF000);
        run_program(1'b0);
        chk("mul_0x0100", mem[0] == 16'h0000 && output_reg == 16'h0000, 1);
        chk("mul_not_illegal", illegal_op, 0);
        chk("mul_last_write", last_wr_data, 16'h0000);
`else
        clear_mem();
        load(0, 16'hB111); load(1, 16'hF000);
        run_program(1'b0);
        chk("opB_illegal", illegal_op, 1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: got 1 expected 0");
        $fatal(1, "timeout");
    end

endmodule
